lmsm_sequencer: RTL
===================

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock shared with data_memory and register file.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 is_store  in  1  1 = SM (register->memory), 0 = LM (memory->register); latched at start.
REQ-006 base_addr  in  16  first memory address; latched at start.
REQ-007 reg_list  in  8  bit i set = transfer register Ri; latched at start.
REQ-008 rf_rd_data  in  16  combinational register-file read data for rf_rd_addr.
REQ-009 mem_read_data  in  16  combinational data_memory read data.
REQ-010 mem_access_addr  out  16  address to data_memory.
REQ-011 mem_write / mem_read  out  1 each  data_memory strobes.
REQ-012 mem_write_data  out  16  store data to data_memory.
REQ-013 rf_rd_addr  out  3  register-file read index.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_wr_addr  out  3  register-file write index.
REQ-016 rf_wr_data  out  16  register-file write data.
REQ-017 busy  out  1  high in XFER and DONE.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, XFER and DONE, held in registered state, mask[7:0], addr[15:0] and dir.
REQ-020 IDLE, start=1, reg_list!=0 at an edge: latch mask=reg_list, addr=base_addr, dir=is_store; go to XFER.
REQ-021 IDLE, start=1, reg_list==0: go directly to DONE; no memory or register access occurs.
REQ-022 start SHALL be ignored in XFER and DONE; it has no queueing or restart effect.
REQ-023 XFER: idx = index of the lowest set bit of mask, from a combinational priority encoder; ascending order R0..R7.
REQ-024 XFER store: mem_access_addr=addr, mem_write=1, rf_rd_addr=idx, mem_write_data=rf_rd_data, rf_we=0, mem_read=0.
REQ-025 XFER load: mem_access_addr=addr, mem_read=1, rf_we=1, rf_wr_addr=idx, rf_wr_data=mem_read_data, mem_write=0.
REQ-026 Each XFER edge: clear mask[idx], addr=addr+1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-027 XFER transitions to DONE on the edge where the mask becomes zero; otherwise it stays in XFER.
REQ-028 DONE: done=1 for exactly one cycle, no strobes, then IDLE unconditionally.
REQ-029 Latency: for N set bits, N XFER cycles follow the start edge, and done is asserted in cycle N+1 (cycle 1 for N=0).
REQ-030 Outside XFER: mem_write, mem_read and rf_we SHALL be 0.
REQ-031 Outside XFER: mem_access_addr, mem_write_data, rf_wr_data, rf_rd_addr and rf_wr_addr SHALL be 0.
REQ-032 At most one memory strobe and one register transfer SHALL occur per cycle; mem_write and mem_read are never both 1.
REQ-033 Inputs base_addr, reg_list and is_store SHALL be ignored after the start edge; changes do not affect an operation in progress.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, mask=0, addr=0, dir=0, and all outputs 0, regardless of clock.
REQ-035 Reset asserted mid-XFER SHALL abort the transfer; no further strobes, and done is not asserted.
REQ-036 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-037 SM: base=0x0010, list=0x05, R0=0xAAAA, R2=0x5555 -> 2 XFER cycles; writes 0xAAAA@0x0010, 0x5555@0x0011; done in cycle 3.
REQ-038 LM: base=0x0020, list=0xFF, mem[i]=i -> R0..R7 get 0x0020..0x0027 over 8 cycles; rf_wr_addr 0..7 ascending; done in cycle 9.
REQ-039 Empty list: start with list=0x00 -> no strobes; busy=1 and done=1 in cycle 1; IDLE in cycle 2.
REQ-040 Wrap: SM base=0xFFFF, list=0x81 -> R0 written @0xFFFF, R7 written @0x0000.
REQ-041 start is re-pulsed with different inputs during XFER -> ignored; original sequence completes unchanged.
REQ-042 rst_n pulsed low in the 2nd XFER cycle of list=0x0F -> strobes drop asynchronously, no done, IDLE; a new start afterwards runs normally.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: one register<->memory word per XFER cycle, lowest register first.
// Latency: N XFER cycles after the start edge, done pulse in cycle N+1; no backpressure, start is ignored while busy.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] base_addr,
  input  logic [7:0]  reg_list,
  input  logic [15:0] rf_rd_data,
  input  logic [15:0] mem_read_data,
  output logic [15:0] mem_access_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic [15:0] mem_write_data,
  output logic [2:0]  rf_rd_addr,
  output logic        rf_we,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_mask;
  logic [15:0] r_addr;
  logic        r_dir;

  state_t      w_state_nxt;
  logic [7:0]  w_mask_nxt;
  logic [15:0] w_addr_nxt;
  logic        w_dir_nxt;
  logic [2:0]  w_idx;

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= 8'd0;
      r_addr  <= 16'd0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_addr  <= w_addr_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mask_nxt      = r_mask;
    w_addr_nxt      = r_addr;
    w_dir_nxt       = r_dir;
    mem_access_addr = 16'd0;
    mem_write       = 1'b0;
    mem_read        = 1'b0;
    mem_write_data  = 16'd0;
    rf_rd_addr      = 3'd0;
    rf_we           = 1'b0;
    rf_wr_addr      = 3'd0;
    rf_wr_data      = 16'd0;
    busy            = 1'b0;
    done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (reg_list != 8'd0) begin
            w_mask_nxt  = reg_list;
            w_addr_nxt  = base_addr;
            w_dir_nxt   = is_store;
            w_state_nxt = S_XFER;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_XFER: begin
        busy            = 1'b1;
        mem_access_addr = r_addr;
        if (r_dir) begin
          mem_write      = 1'b1;
          rf_rd_addr     = w_idx;
          mem_write_data = rf_rd_data;
        end else begin
          mem_read   = 1'b1;
          rf_we      = 1'b1;
          rf_wr_addr = w_idx;
          rf_wr_data = mem_read_data;
        end
        w_mask_nxt = r_mask & ~(8'd1 << w_idx);
        w_addr_nxt = r_addr + 16'd1;
        if (w_mask_nxt == 8'd0) w_state_nxt = S_DONE;
      end

      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
